// File: rtl/ans_ctrl_pkg.sv
// rtl/ans_ctrl_pkg.sv - shared encodings, state enum and widths for the ANS frame controller.
package ans_ctrl_pkg;

  localparam int SYM_WIDTH = 4;
  localparam int CNT_WIDTH = 4;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_ENC  = 2'b01;
  localparam logic [1:0] CMD_DEC  = 2'b10;
  localparam logic [1:0] CMD_LOAD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic logic op_legal(input logic [1:0] op);
    return (op == CMD_ENC) || (op == CMD_DEC);
  endfunction

endpackage

// File: rtl/ans_ctrl.sv
// rtl/ans_ctrl.sv - frame controller sequencing table load, symbol run and drain for an ANS core.
module ans_ctrl
  import ans_ctrl_pkg::*;
#(
  parameter int LOAD_LEN  = 16,
  parameter int DRAIN_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [1:0]           i_op,
  input  logic                 i_need_load,
  input  logic [7:0]           i_frame_len,
  input  logic                 i_abort,
  input  logic [SYM_WIDTH-1:0] i_host_in,
  input  logic                 i_host_vld,
  output logic                 o_host_rdy,
  output logic [1:0]           o_core_cmd,
  output logic [SYM_WIDTH-1:0] o_core_in,
  output logic                 o_core_in_vld,
  input  logic                 i_core_in_rdy,
  input  logic                 i_core_out_vld,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic                 o_table_valid
);

  localparam int DRAIN_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [CNT_WIDTH-1:0] LOAD_LAST  = CNT_WIDTH'(LOAD_LEN - 1);
  localparam logic [DRAIN_W-1:0]   DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);

  state_t               r_state;
  logic [1:0]           r_op;
  logic [1:0]           r_core_cmd;
  logic [8:0]           r_sym_cnt;
  logic [CNT_WIDTH-1:0] r_load_cnt;
  logic [DRAIN_W-1:0]   r_drain_cnt;
  logic                 r_done;
  logic                 r_err;
  logic                 r_table_valid;

  logic       w_active;
  logic       w_xfer;
  logic       w_reject;
  logic [8:0] w_len_init;

  // Host/core handshake is passed straight through only while nibbles are being consumed.
  assign w_active      = (r_state == ST_LOAD) || (r_state == ST_RUN);
  assign o_host_rdy    = w_active & i_core_in_rdy;
  assign o_core_in_vld = w_active & i_host_vld;
  assign o_core_in     = i_host_in;
  assign w_xfer        = i_host_vld & o_host_rdy;

  assign w_reject   = !op_legal(i_op) || (!i_need_load && !r_table_valid);
  assign w_len_init = (i_frame_len == 8'd0) ? 9'd256 : {1'b0, i_frame_len};

  assign o_core_cmd    = r_core_cmd;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_table_valid = r_table_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_op          <= CMD_IDLE;
      r_core_cmd    <= CMD_IDLE;
      r_sym_cnt     <= '0;
      r_load_cnt    <= '0;
      r_drain_cnt   <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_table_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (i_abort) begin
        r_state    <= ST_IDLE;
        r_core_cmd <= CMD_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              if (w_reject) begin
                r_err <= 1'b1;
              end else begin
                r_op      <= i_op;
                r_sym_cnt <= w_len_init;
                if (i_need_load) begin
                  r_state       <= ST_LOAD;
                  r_core_cmd    <= CMD_LOAD;
                  r_load_cnt    <= '0;
                  r_table_valid <= 1'b0;
                end else begin
                  r_state    <= ST_RUN;
                  r_core_cmd <= i_op;
                end
              end
            end
          end
          ST_LOAD: begin
            if (w_xfer) begin
              if (r_load_cnt == LOAD_LAST) begin
                r_table_valid <= 1'b1;
                r_state       <= ST_RUN;
                r_core_cmd    <= r_op;
              end else begin
                r_load_cnt <= r_load_cnt + 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (w_xfer) begin
              r_sym_cnt <= r_sym_cnt - 9'd1;
              if (r_sym_cnt == 9'd1) begin
                r_state     <= ST_DRAIN;
                r_drain_cnt <= '0;
              end
            end
          end
          ST_DRAIN: begin
            if (!i_core_out_vld) begin
              r_state    <= ST_DONE;
              r_core_cmd <= CMD_IDLE;
              r_done     <= 1'b1;
            end else if (r_drain_cnt == DRAIN_LAST) begin
              r_state    <= ST_IDLE;
              r_core_cmd <= CMD_IDLE;
              r_err      <= 1'b1;
            end else begin
              r_drain_cnt <= r_drain_cnt + 1'b1;
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state    <= ST_IDLE;
            r_core_cmd <= CMD_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ans_ctrl.sv
// tb/tb_ans_ctrl.sv - directed self-checking bench for ans_ctrl.
module tb_ans_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start;
  logic [1:0] i_op;
  logic       i_need_load;
  logic [7:0] i_frame_len;
  logic       i_abort;
  logic [3:0] i_host_in;
  logic       i_host_vld;
  logic       o_host_rdy;
  logic [1:0] o_core_cmd;
  logic [3:0] o_core_in;
  logic       o_core_in_vld;
  logic       i_core_in_rdy;
  logic       i_core_out_vld;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic       o_table_valid;

  int checks = 0;
  int failures = 0;

  ans_ctrl #(.LOAD_LEN(16), .DRAIN_MAX(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_op          (i_op),
    .i_need_load   (i_need_load),
    .i_frame_len   (i_frame_len),
    .i_abort       (i_abort),
    .i_host_in     (i_host_in),
    .i_host_vld    (i_host_vld),
    .o_host_rdy    (o_host_rdy),
    .o_core_cmd    (o_core_cmd),
    .o_core_in     (o_core_in),
    .o_core_in_vld (o_core_in_vld),
    .i_core_in_rdy (i_core_in_rdy),
    .i_core_out_vld(i_core_out_vld),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err),
    .o_table_valid (o_table_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_nibbles(input int n);
    i_host_vld    = 1'b1;
    i_core_in_rdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      i_host_in = 4'(i);
      tick();
    end
    i_host_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_op = 2'b00; i_need_load = 1'b0; i_frame_len = 8'd0;
    i_abort = 1'b0; i_host_in = 4'd0; i_host_vld = 1'b0; i_core_in_rdy = 1'b0; i_core_out_vld = 1'b0;
    tick(); tick();
    checks++;
    if ({o_busy, o_core_cmd, o_done, o_err, o_table_valid, o_host_rdy, o_core_in_vld} !== 8'b0) begin
      failures++;
      $display("FAIL reset_state got busy=%b cmd=%b done=%b err=%b tv=%b rdy=%b vld=%b want all 0",
               o_busy, o_core_cmd, o_done, o_err, o_table_valid, o_host_rdy, o_core_in_vld);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_no_table();
    i_start = 1'b1; i_op = 2'b01; i_need_load = 1'b0; i_frame_len = 8'd3;
    tick();
    i_start = 1'b0;
    checks++;
    if ({o_err, o_busy, o_table_valid, o_core_cmd} !== 5'b10000) begin
      failures++;
      $display("FAIL no_table_err got err=%b busy=%b tv=%b cmd=%b want err=1 busy=0 tv=0 cmd=00",
               o_err, o_busy, o_table_valid, o_core_cmd);
    end
    tick();
    checks++;
    if (o_err !== 1'b0) begin
      failures++;
      $display("FAIL no_table_err_pulse got err=%b want 0", o_err);
    end
  endtask

  task automatic test_illegal_op();
    logic [1:0] bad_ops [2];
    bad_ops[0] = 2'b11;
    bad_ops[1] = 2'b00;
    for (int k = 0; k < 2; k++) begin
      i_start = 1'b1; i_op = bad_ops[k]; i_need_load = 1'b1; i_frame_len = 8'd4;
      tick();
      i_start = 1'b0;
      checks++;
      if ({o_err, o_busy, o_core_cmd} !== 4'b1000) begin
        failures++;
        $display("FAIL illegal_op_%b got err=%b busy=%b cmd=%b want err=1 busy=0 cmd=00",
                 bad_ops[k], o_err, o_busy, o_core_cmd);
      end
      tick();
    end
  endtask

  task automatic test_abort_start_idle();
    i_start = 1'b1; i_abort = 1'b1; i_op = 2'b01; i_need_load = 1'b1; i_frame_len = 8'd2;
    tick();
    i_start = 1'b0; i_abort = 1'b0;
    checks++;
    if ({o_busy, o_err, o_core_cmd} !== 4'b0000) begin
      failures++;
      $display("FAIL abort_beats_start got busy=%b err=%b cmd=%b want 0 0 00", o_busy, o_err, o_core_cmd);
    end
  endtask

  task automatic test_load_encode();
    i_start = 1'b1; i_op = 2'b01; i_need_load = 1'b1; i_frame_len = 8'd3;
    i_core_in_rdy = 1'b1; i_core_out_vld = 1'b0;
    tick();
    i_start = 1'b0;
    i_host_vld = 1'b1;
    for (int i = 0; i < 19; i++) begin
      logic [1:0] want_cmd;
      want_cmd = (i < 16) ? 2'b11 : 2'b01;
      i_host_in = 4'(i + 5);
      #1;
      checks++;
      if ({o_core_cmd, o_host_rdy, o_core_in_vld, o_core_in} !== {want_cmd, 2'b11, 4'(i + 5)}) begin
        failures++;
        $display("FAIL load_encode_xfer%0d got cmd=%b rdy=%b vld=%b in=%h want cmd=%b rdy=1 vld=1 in=%h",
                 i, o_core_cmd, o_host_rdy, o_core_in_vld, o_core_in, want_cmd, 4'(i + 5));
      end
      tick();
    end
    #1;
    checks++;
    if ({o_host_rdy, o_busy, o_core_cmd, o_table_valid} !== 5'b01011) begin
      failures++;
      $display("FAIL load_encode_drain got rdy=%b busy=%b cmd=%b tv=%b want rdy=0 busy=1 cmd=01 tv=1",
               o_host_rdy, o_busy, o_core_cmd, o_table_valid);
    end
    i_host_vld = 1'b0;
    tick();
    checks++;
    if ({o_done, o_busy, o_core_cmd} !== 4'b1100) begin
      failures++;
      $display("FAIL load_encode_done got done=%b busy=%b cmd=%b want done=1 busy=1 cmd=00",
               o_done, o_busy, o_core_cmd);
    end
    tick();
    checks++;
    if ({o_done, o_busy, o_table_valid} !== 3'b001) begin
      failures++;
      $display("FAIL load_encode_idle got done=%b busy=%b tv=%b want 0 0 1", o_done, o_busy, o_table_valid);
    end
  endtask

  task automatic test_decode_256();
    int xfers;
    xfers = 0;
    i_start = 1'b1; i_op = 2'b10; i_need_load = 1'b0; i_frame_len = 8'd0;
    tick();
    i_start = 1'b0;
    checks++;
    if (o_core_cmd !== 2'b10) begin
      failures++;
      $display("FAIL decode_cmd got cmd=%b want 10", o_core_cmd);
    end
    i_host_vld = 1'b1;
    for (int c = 0; c < 700 && xfers < 256; c++) begin
      i_core_in_rdy = (c % 3) != 1;
      i_host_in = 4'(c);
      #1;
      if (o_host_rdy !== i_core_in_rdy) begin
        checks++;
        failures++;
        $display("FAIL decode_rdy_follow cycle %0d got rdy=%b want %b after %0d xfers",
                 c, o_host_rdy, i_core_in_rdy, xfers);
      end
      if (o_host_rdy === 1'b1) xfers++;
      tick();
    end
    checks++;
    if (xfers !== 256) begin
      failures++;
      $display("FAIL decode_count got %0d transfers want 256", xfers);
    end
    i_core_in_rdy = 1'b1;
    #1;
    checks++;
    if ({o_host_rdy, o_busy, o_core_cmd} !== 4'b0110) begin
      failures++;
      $display("FAIL decode_drain got rdy=%b busy=%b cmd=%b want rdy=0 busy=1 cmd=10",
               o_host_rdy, o_busy, o_core_cmd);
    end
    i_host_vld = 1'b0;
    tick();
    checks++;
    if (o_done !== 1'b1) begin
      failures++;
      $display("FAIL decode_done got done=%b want 1", o_done);
    end
    tick();
  endtask

  task automatic test_drain_timeout();
    i_core_out_vld = 1'b1;
    i_start = 1'b1; i_op = 2'b01; i_need_load = 1'b0; i_frame_len = 8'd1;
    tick();
    i_start = 1'b0;
    send_nibbles(1);
    for (int k = 0; k < 14; k++) begin
      tick();
      checks++;
      if ({o_err, o_busy, o_done} !== 3'b010) begin
        failures++;
        $display("FAIL drain_hold%0d got err=%b busy=%b done=%b want 0 1 0", k, o_err, o_busy, o_done);
      end
    end
    tick();
    checks++;
    if ({o_err, o_busy, o_done, o_core_cmd} !== 5'b10000) begin
      failures++;
      $display("FAIL drain_timeout got err=%b busy=%b done=%b cmd=%b want 1 0 0 00",
               o_err, o_busy, o_done, o_core_cmd);
    end
    i_core_out_vld = 1'b0;
    tick();
    checks++;
    if ({o_err, o_done} !== 2'b00) begin
      failures++;
      $display("FAIL drain_timeout_after got err=%b done=%b want 0 0", o_err, o_done);
    end
  endtask

  task automatic test_start_in_run();
    i_start = 1'b1; i_op = 2'b01; i_need_load = 1'b1; i_frame_len = 8'd2;
    tick();
    i_start = 1'b0;
    send_nibbles(16);
    i_start = 1'b1; i_op = 2'b10; i_need_load = 1'b1; i_host_vld = 1'b1;
    tick();
    i_start = 1'b0;
    checks++;
    if ({o_core_cmd, o_err, o_table_valid, o_busy} !== 5'b01011) begin
      failures++;
      $display("FAIL start_in_run got cmd=%b err=%b tv=%b busy=%b want 01 0 1 1",
               o_core_cmd, o_err, o_table_valid, o_busy);
    end
    tick();
    i_host_vld = 1'b0;
    tick();
    checks++;
    if ({o_done, o_err} !== 2'b10) begin
      failures++;
      $display("FAIL start_in_run_done got done=%b err=%b want 1 0", o_done, o_err);
    end
    tick();
  endtask

  task automatic test_abort_load();
    i_start = 1'b1; i_op = 2'b01; i_need_load = 1'b1; i_frame_len = 8'd2;
    tick();
    i_start = 1'b0;
    checks++;
    if ({o_table_valid, o_core_cmd} !== 3'b011) begin
      failures++;
      $display("FAIL load_entry got tv=%b cmd=%b want tv=0 cmd=11", o_table_valid, o_core_cmd);
    end
    send_nibbles(7);
    i_host_vld = 1'b1; i_abort = 1'b1;
    tick();
    i_host_vld = 1'b0; i_abort = 1'b0;
    checks++;
    if ({o_busy, o_core_cmd, o_table_valid, o_err, o_done} !== 6'b0) begin
      failures++;
      $display("FAIL abort_load got busy=%b cmd=%b tv=%b err=%b done=%b want all 0",
               o_busy, o_core_cmd, o_table_valid, o_err, o_done);
    end
    tick();
    checks++;
    if ({o_err, o_done, o_busy} !== 3'b0) begin
      failures++;
      $display("FAIL abort_load_after got err=%b done=%b busy=%b want 0 0 0", o_err, o_done, o_busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    i_start = 1'b1; i_op = 2'b10; i_need_load = 1'b1; i_frame_len = 8'd5;
    tick();
    i_start = 1'b0;
    send_nibbles(3);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_core_cmd} !== 3'b000) begin
      failures++;
      $display("FAIL async_reset got busy=%b cmd=%b want 0 00", o_busy, o_core_cmd);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({o_done, o_err, o_table_valid, o_busy} !== 4'b0) begin
      failures++;
      $display("FAIL reset_mid_frame got done=%b err=%b tv=%b busy=%b want all 0",
               o_done, o_err, o_table_valid, o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_no_table();
    test_illegal_op();
    test_abort_start_idle();
    test_load_encode();
    test_decode_256();
    test_drain_timeout();
    test_start_in_run();
    test_abort_load();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ans_ctrl.md
ANS_CTRL -- requirements
Module: ans_ctrl

Interface
REQ-001 Parameter LOAD_LEN, default 16, number of count nibbles per table load (one per symbol).
REQ-002 Parameter DRAIN_MAX, default 15, maximum DRAIN cycles before timeout.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle frame request; sampled only in IDLE.
REQ-006 op  input  2  frame op, sampled with start: 01 encode, 10 decode; 00/11 illegal.
REQ-007 need_load  input  1  sampled with start; 1 = frame begins with a table load.
REQ-008 frame_len  input  8  symbols in frame, sampled with start; 0 means 256.
REQ-009 abort  input  1  synchronous abort, any state.
REQ-010 host_in  input  4  host nibble (count or symbol).
REQ-011 host_vld  input  1  host nibble valid.
REQ-012 host_rdy  output  1  controller accepts host nibble.
REQ-013 core_cmd  output  2  command to ANS core: 00 idle, 01 enc, 10 dec, 11 load.
REQ-014 core_in  output  4  nibble to core; equals host_in.
REQ-015 core_in_vld  output  1  nibble valid to core.
REQ-016 core_in_rdy  input  1  core ready.
REQ-017 core_out_vld  input  1  core output valid; observed for drain only.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse on successful frame end.
REQ-020 err  output  1  one-cycle pulse on rejected start or drain timeout.
REQ-021 table_valid  output  1  a complete table load has finished.

Function
REQ-022 States IDLE, LOAD, RUN, DRAIN, DONE; encoded as a registered FSM.
REQ-023 core_cmd is registered: 00 in IDLE/DONE, 11 in LOAD, latched op in RUN/DRAIN.
REQ-024 In LOAD/RUN: core_in_vld = host_vld, host_rdy = core_in_rdy (combinational); elsewhere both 0.
REQ-025 Transfer occurs on a cycle with host_vld and host_rdy both high; only transfers advance counters.
REQ-026 IDLE + start with legal op: latch op and frame_len (8-bit counter, 0 loaded as 256 via 9-bit count); go LOAD if need_load, else RUN.
REQ-027 IDLE + start with illegal op, or need_load=0 while table_valid=0: err pulse next cycle, remain IDLE.
REQ-028 LOAD: 4-bit load counter starts at 0; on the transfer with counter = LOAD_LEN-1 set table_valid, go RUN.
REQ-029 Entering LOAD clears table_valid in the same edge.
REQ-030 RUN: symbol counter decrements per transfer; on the transfer that reaches 0, go DRAIN.
REQ-031 DRAIN: holds core_cmd; exits to DONE on the first cycle core_out_vld=0; if core_out_vld stays high for DRAIN_MAX cycles, err pulse and go IDLE.
REQ-032 DONE: lasts exactly one cycle, done=1, then IDLE.
REQ-033 Start outside IDLE is ignored without err.
REQ-034 abort: next state IDLE from any state, core_cmd 00 next cycle, no done/err; abort in LOAD leaves table_valid 0.
REQ-035 abort and start in same IDLE cycle: abort wins, start ignored.
REQ-036 Minimum latency start -> first core_cmd change: one cycle.

Reset
REQ-037 rst_n low asynchronously forces IDLE, core_cmd=00, all counters 0, latched op 00, busy=0, done=0, err=0, table_valid=0.
REQ-038 Reset mid-frame discards the frame; no done or err is generated.

Structure
REQ-039 Shared package holds the cmd encodings (IDLE/ENC/DEC/LOAD), the FSM state enum, SYM_WIDTH=4 and CNT_WIDTH=4.
REQ-040 Single flat module; no sub-module.

Verification
REQ-041 Reset, start op=01 need_load=0 -> err pulse, stays IDLE, table_valid=0.
REQ-042 start op=01 need_load=1 len=3, 16 counts then 3 symbols, core_in_rdy=1 -> core_cmd 11 for 16 transfers, 01 for 3, DRAIN, done pulse, table_valid=1.
REQ-043 start op=10 need_load=0 len=0, core_in_rdy toggling -> exactly 256 transfers accepted before DRAIN.
REQ-044 core_out_vld held high in DRAIN -> err pulse after 15 cycles, IDLE, no done.
REQ-045 abort on 8th LOAD transfer -> IDLE next cycle, core_cmd 00, table_valid=0.
REQ-046 start op=11 -> err pulse; start asserted during RUN -> ignored, frame completes normally.
